// File: rtl/state_dump.sv
// Scans the register file and/or data memory and streams every entry
// out over a valid/ready port, tagged with its source and index.
module state_dump #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NMEM   = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    output logic [IDX_W-1:0]  reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [IDX_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tag,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MEM,
        FLUSH,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NREGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(NMEM - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       mode_q;
    logic             free;

    assign free = !out_valid || out_ready;

    assign reg_raddr = (state == REG && mode_q[0]) ? idx : '0;
    assign mem_raddr = (state == MEM) ? idx : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            mode_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done trails the DONE state by one edge, a single pulse
            done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (start) begin
                        mode_q <= mode;
                        idx    <= '0;
                        if (mode[0]) begin
                            state <= REG;
                        end else if (mode[1]) begin
                            state <= MEM;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REG: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= IDLE;
                    end else if (free) begin
                        out_valid <= 1'b1;
                        out_data  <= reg_rdata;
                        out_tag   <= 1'b0;
                        out_idx   <= idx;
                        out_last  <= (idx == REG_LAST) && !mode_q[1];
                        if (idx == REG_LAST) begin
                            idx   <= '0;
                            state <= mode_q[1] ? MEM : FLUSH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= IDLE;
                    end else if (free) begin
                        out_valid <= 1'b1;
                        out_data  <= mem_rdata;
                        out_tag   <= 1'b1;
                        out_idx   <= idx;
                        out_last  <= (idx == MEM_LAST);
                        if (idx == MEM_LAST) begin
                            idx   <= '0;
                            state <= FLUSH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= IDLE;
                    end else if (!out_valid || (out_ready && out_last)) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump.sv
// Directed bench for state_dump: expected words go into a queue when a
// dump is started, a negedge monitor pops them on every handshake.
module tb_state_dump;

    typedef struct packed {
        logic [31:0] data;
        logic        tag;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        abort;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic [4:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_tag;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [31:0] mems [32];
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;
    logic [3:0]  pat = 4'b1001;

    always #5 clk = ~clk;

    assign reg_rdata = regs[reg_raddr];
    assign mem_rdata = mems[mem_raddr];

    state_dump dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on handshake and checks holding during stalls
    logic  stall = 1'b0;
    exp_t  held;
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = '{out_data, out_tag, out_idx, out_last};
        if (!rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold", {out_valid, got}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
                check("queue_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("word", 64'(got), 64'(e));
                end
            end
            stall = out_valid && !out_ready;
            held  = got;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 2'b00;
    endtask

    task automatic push_regs(input bit is_final);
        for (int i = 0; i < 32; i++) begin
            q.push_back('{regs[i], 1'b0, 5'(i), is_final && i == 31});
        end
    endtask

    task automatic push_mems();
        for (int i = 0; i < 32; i++) begin
            q.push_back('{mems[i], 1'b1, 5'(i), i == 31});
        end
    endtask

    task automatic watch(input bit bp, input int poke, input int maxc,
                         output int first_v, output int nvalid,
                         output int last_v, output int done_t,
                         output int done_n);
        first_v = -1;
        nvalid  = 0;
        last_v  = -1;
        done_t  = -1;
        done_n  = 0;
        for (int n = 1; n <= maxc; n++) begin
            if (bp) out_ready = pat[(n - 1) % 4];
            if (n == poke) begin
                start = 1'b1;
                mode  = 2'b10;
            end else if (n == poke + 1) begin
                start = 1'b0;
                mode  = 2'b00;
            end
            tick();
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = n;
                last_v = n;
            end
            if (done) begin
                done_n++;
                if (done_t < 0) done_t = n;
            end
            if (done_t > 0 && n >= done_t + 2) break;
        end
        out_ready = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
    endtask

    localparam logic [49:0] ZERO = '0;

    function automatic logic [49:0] outs();
        return {out_valid, out_data, out_tag, out_idx, out_last,
                busy, done, reg_raddr, mem_raddr};
    endfunction

    initial begin
        int fv, nv, lv, dt, dn, hits;
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 2'b00;
        abort     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'(i * 3);
            mems[i] = 32'(100 + i);
        end
        #2;
        check("reset_outs", 64'(outs()), 64'(ZERO));
        tick();
        rst = 1'b1;
        tick();

        // register-only dump at full throughput
        push_regs(1'b1);
        kick(2'b01);
        check("e0_valid", 64'(out_valid), 64'd0);
        check("e0_busy", 64'(busy), 64'd1);
        watch(1'b0, 0, 60, fv, nv, lv, dt, dn);
        check("reg_first", 64'(fv), 64'd1);
        check("reg_count", 64'(nv), 64'd32);
        check("reg_lastv", 64'(lv), 64'd32);
        check("reg_done_t", 64'(dt), 64'd34);
        check("reg_done_n", 64'(dn), 64'd1);
        check("reg_drain", 64'(q.size()), 64'd0);

        // registers then memory, no gap
        push_regs(1'b0);
        push_mems();
        kick(2'b11);
        watch(1'b0, 0, 100, fv, nv, lv, dt, dn);
        check("both_first", 64'(fv), 64'd1);
        check("both_count", 64'(nv), 64'd64);
        check("both_lastv", 64'(lv), 64'd64);
        check("both_done_t", 64'(dt), 64'd66);
        check("both_done_n", 64'(dn), 64'd1);
        check("both_drain", 64'(q.size()), 64'd0);

        // memory-only under 1,0,0,1 backpressure
        push_mems();
        kick(2'b10);
        watch(1'b1, 0, 200, fv, nv, lv, dt, dn);
        check("bp_done_n", 64'(dn), 64'd1);
        check("bp_drain", 64'(q.size()), 64'd0);

        // empty dump
        kick(2'b00);
        check("empty_busy", 64'(busy), 64'd1);
        watch(1'b0, 0, 10, fv, nv, lv, dt, dn);
        check("empty_valid", 64'(nv), 64'd0);
        check("empty_done_t", 64'(dt), 64'd1);
        check("empty_done_n", 64'(dn), 64'd1);

        // start re-pulsed mid-dump is ignored
        push_regs(1'b1);
        kick(2'b01);
        watch(1'b0, 5, 60, fv, nv, lv, dt, dn);
        check("ovl_count", 64'(nv), 64'd32);
        check("ovl_lastv", 64'(lv), 64'd32);
        check("ovl_done_t", 64'(dt), 64'd34);
        check("ovl_drain", 64'(q.size()), 64'd0);

        // abort while word 10 is presented
        for (int i = 0; i <= 10; i++) begin
            q.push_back('{regs[i], 1'b0, 5'(i), 1'b0});
        end
        kick(2'b01);
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid && out_idx == 5'd10) begin
                hits = 1;
                break;
            end
        end
        check("abort_reach", 64'(hits), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) hits++;
            tick();
        end
        check("abort_nodone", 64'(hits), 64'd0);
        check("abort_drain", 64'(q.size()), 64'd0);
        push_regs(1'b1);
        kick(2'b01);
        watch(1'b0, 0, 60, fv, nv, lv, dt, dn);
        check("post_abort_cnt", 64'(nv), 64'd32);
        check("post_abort_dn", 64'(dn), 64'd1);
        check("post_abort_drain", 64'(q.size()), 64'd0);

        // asynchronous reset during the memory phase
        push_regs(1'b0);
        push_mems();
        kick(2'b11);
        hits = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (out_valid && out_tag && out_idx == 5'd5) begin
                hits = 1;
                break;
            end
        end
        check("rst_reach", 64'(hits), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("rst_async", 64'(outs()), 64'(ZERO));
        q.delete();
        tick();
        check("rst_hold", 64'(outs()), 64'(ZERO));
        rst = 1'b1;
        tick();
        push_regs(1'b0);
        push_mems();
        kick(2'b11);
        watch(1'b0, 0, 100, fv, nv, lv, dt, dn);
        check("rst_first", 64'(fv), 64'd1);
        check("rst_count", 64'(nv), 64'd64);
        check("rst_done_n", 64'(dn), 64'd1);
        check("rst_drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
